hack_kbd_writer: RTL and testbench

//   Writer side of the Hack keyboard memory map (KBD, 0x6000). Receives PS/2

---
 rtl/hack_kbd_pkg.sv | 44 ++++
 rtl/ps2_scancode_map.sv | 116 +++++++++++
 rtl/hack_kbd_writer.sv | 238 +++++++++++++++++++++++
 tb/tb_hack_kbd_writer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hack_kbd_pkg.sv
// Shared constants and state types for the Hack keyboard writer.
package hack_kbd_pkg;

   localparam logic [15:0] KC_NEWLINE = 16'd128;
   localparam logic [15:0] KC_BKSP    = 16'd129;
   localparam logic [15:0] KC_LEFT    = 16'd130;
   localparam logic [15:0] KC_UP      = 16'd131;
   localparam logic [15:0] KC_RIGHT   = 16'd132;
   localparam logic [15:0] KC_DOWN    = 16'd133;
   localparam logic [15:0] KC_HOME    = 16'd134;
   localparam logic [15:0] KC_END     = 16'd135;
   localparam logic [15:0] KC_PGUP    = 16'd136;
   localparam logic [15:0] KC_PGDN    = 16'd137;
   localparam logic [15:0] KC_INS     = 16'd138;
   localparam logic [15:0] KC_DEL     = 16'd139;
   localparam logic [15:0] KC_ESC     = 16'd140;
   localparam logic [15:0] KC_F1      = 16'd141;
   localparam logic [15:0] KC_F12     = 16'd152;

   localparam logic [7:0] SC_E0     = 8'hE0;
   localparam logic [7:0] SC_F0     = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;

   typedef enum logic [1:0] {
      FR_IDLE,
      FR_DATA,
      FR_PARITY,
      FR_STOP
   } frame_state_t;

   typedef enum logic [1:0] {
      DEC_NORM,
      DEC_E0,
      DEC_F0,
      DEC_E0F0
   } dec_state_t;

   // PS/2 uses odd parity over the 8 data bits plus the parity bit.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_scancode_map.sv
// Set-2 scancode to Hack keycode lookup. Purely combinational; 0 = unmapped.
module ps2_scancode_map (
   input  logic        ext,
   input  logic        shift,
   input  logic [7:0]  scan,
   output logic [15:0] code
);
   import hack_kbd_pkg::*;

   logic [7:0]  lo;
   logic [7:0]  hi;
   logic [15:0] special;

   // Table lookup; letters derive their shifted form, other printables are explicit.
   always_comb begin
      lo      = 8'd0;
      hi      = 8'd0;
      special = 16'd0;
      if (ext) begin
         case (scan)
            8'h6B:   special = KC_LEFT;
            8'h75:   special = KC_UP;
            8'h74:   special = KC_RIGHT;
            8'h72:   special = KC_DOWN;
            8'h6C:   special = KC_HOME;
            8'h69:   special = KC_END;
            8'h7D:   special = KC_PGUP;
            8'h7A:   special = KC_PGDN;
            8'h70:   special = KC_INS;
            8'h71:   special = KC_DEL;
            8'h5A:   special = KC_NEWLINE;
            default: special = 16'd0;
         endcase
      end else begin
         case (scan)
            8'h1C: lo = "a";
            8'h32: lo = "b";
            8'h21: lo = "c";
            8'h23: lo = "d";
            8'h24: lo = "e";
            8'h2B: lo = "f";
            8'h34: lo = "g";
            8'h33: lo = "h";
            8'h43: lo = "i";
            8'h3B: lo = "j";
            8'h42: lo = "k";
            8'h4B: lo = "l";
            8'h3A: lo = "m";
            8'h31: lo = "n";
            8'h44: lo = "o";
            8'h4D: lo = "p";
            8'h15: lo = "q";
            8'h2D: lo = "r";
            8'h1B: lo = "s";
            8'h2C: lo = "t";
            8'h3C: lo = "u";
            8'h2A: lo = "v";
            8'h1D: lo = "w";
            8'h22: lo = "x";
            8'h35: lo = "y";
            8'h1A: lo = "z";
            8'h45: begin lo = "0"; hi = ")"; end
            8'h16: begin lo = "1"; hi = "!"; end
            8'h1E: begin lo = "2"; hi = "@"; end
            8'h26: begin lo = "3"; hi = "#"; end
            8'h25: begin lo = "4"; hi = "$"; end
            8'h2E: begin lo = "5"; hi = "%"; end
            8'h36: begin lo = "6"; hi = "^"; end
            8'h3D: begin lo = "7"; hi = "&"; end
            8'h3E: begin lo = "8"; hi = "*"; end
            8'h46: begin lo = "9"; hi = "("; end
            8'h29: begin lo = " "; hi = " "; end
            8'h0E: begin lo = 8'h60; hi = 8'h7E; end
            8'h4E: begin lo = "-"; hi = "_"; end
            8'h55: begin lo = "="; hi = "+"; end
            8'h54: begin lo = "["; hi = "{"; end
            8'h5B: begin lo = "]"; hi = "}"; end
            8'h5D: begin lo = "\\"; hi = "|"; end
            8'h4C: begin lo = ";"; hi = ":"; end
            8'h52: begin lo = "'"; hi = "\""; end
            8'h41: begin lo = ","; hi = "<"; end
            8'h49: begin lo = "."; hi = ">"; end
            8'h4A: begin lo = "/"; hi = "?"; end
            8'h5A: special = KC_NEWLINE;
            8'h66: special = KC_BKSP;
            8'h76: special = KC_ESC;
            8'h05: special = KC_F1;
            8'h06: special = 16'd142;
            8'h04: special = 16'd143;
            8'h0C: special = 16'd144;
            8'h03: special = 16'd145;
            8'h0B: special = 16'd146;
            8'h83: special = 16'd147;
            8'h0A: special = 16'd148;
            8'h01: special = 16'd149;
            8'h09: special = 16'd150;
            8'h78: special = 16'd151;
            8'h07: special = KC_F12;
            default: ;
         endcase
         if (lo >= "a" && lo <= "z") begin
            hi = lo - 8'd32;
         end
      end
   end

   // Non-printing keys ignore shift.
   always_comb begin
      if (special != 16'd0) begin
         code = special;
      end else begin
         code = {8'd0, shift ? hi : lo};
      end
   end

endmodule

// File: rtl/hack_kbd_writer.sv
// PS/2 receiver and set-2 decoder feeding the Hack KBD register.
// Build option: define KBD_PARITY_CHECK_EN to reject frames with bad odd parity.
//
// Frame FSM
//   state     | meaning
//   FR_IDLE   | waiting for a start bit (data low on clock fall)
//   FR_DATA   | shifting 8 data bits, LSB first
//   FR_PARITY | capturing the parity bit
//   FR_STOP   | checking the stop bit, byte handed to decoder
// Decode FSM
//   state     | meaning
//   DEC_NORM  | plain make expected
//   DEC_E0    | extended prefix seen
//   DEC_F0    | break prefix seen
//   DEC_E0F0  | extended break prefix seen
module hack_kbd_writer #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] kbd_out,
   output logic        frame_valid,
   output logic        frame_err
);
   import hack_kbd_pkg::*;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   ps2c;
   logic                   ps2d;
   logic                   ps2c_q;
   logic                   fall;

   frame_state_t fr_state, fr_nxt;
   logic [2:0]   bit_cnt, bit_cnt_nxt;
   logic [7:0]   shreg, shreg_nxt;
   logic [7:0]   rx_byte, rx_byte_nxt;
   logic         byte_rdy, byte_rdy_nxt;
   logic         err_nxt;
   logic [TW-1:0] tmr, tmr_nxt;
   logic         tmo;

   dec_state_t   dec_state, dec_nxt;
   logic         shift, shift_nxt;
   logic [15:0]  held_base, held_nxt;
   logic [15:0]  kbd_nxt;
   logic         ext;
   logic         brk;
   logic [15:0]  code_cur;
   logic [15:0]  code_base;

   // Pin synchronisers; reset to the idle-high line level so no false fall appears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         ps2c_q    <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         ps2c_q    <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign ps2c = clk_sync[SYNC_STAGES-1];
   assign ps2d = data_sync[SYNC_STAGES-1];
   assign fall = ps2c_q & ~ps2c;

`ifdef KBD_PARITY_CHECK_EN
   logic par_ok, par_ok_nxt;

   // Parity result is latched when the parity bit arrives, used at the stop bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_ok <= 1'b0;
      end else begin
         par_ok <= par_ok_nxt;
      end
   end
`endif

   // Frame FSM and timeout state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fr_state  <= FR_IDLE;
         bit_cnt   <= 3'd0;
         shreg     <= 8'd0;
         rx_byte   <= 8'd0;
         byte_rdy  <= 1'b0;
         frame_err <= 1'b0;
         tmr       <= TW'(TIMEOUT_CYCLES - 1);
      end else begin
         fr_state  <= fr_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shreg     <= shreg_nxt;
         rx_byte   <= rx_byte_nxt;
         byte_rdy  <= byte_rdy_nxt;
         frame_err <= err_nxt;
         tmr       <= tmr_nxt;
      end
   end

   // Frame FSM next state; the down-counter reloads on every clock fall and in idle.
   always_comb begin
      fr_nxt       = fr_state;
      bit_cnt_nxt  = bit_cnt;
      shreg_nxt    = shreg;
      rx_byte_nxt  = rx_byte;
      byte_rdy_nxt = 1'b0;
      err_nxt      = 1'b0;
`ifdef KBD_PARITY_CHECK_EN
      par_ok_nxt   = par_ok;
`endif
      if (fr_state == FR_IDLE || fall) begin
         tmr_nxt = TW'(TIMEOUT_CYCLES - 1);
      end else if (tmr != '0) begin
         tmr_nxt = tmr - TW'(1);
      end else begin
         tmr_nxt = tmr;
      end
      tmo = (fr_state != FR_IDLE) && (tmr == '0) && !fall;

      case (fr_state)
         FR_IDLE: begin
            if (fall && !ps2d) begin
               fr_nxt      = FR_DATA;
               bit_cnt_nxt = 3'd0;
            end
         end
         FR_DATA: begin
            if (fall) begin
               shreg_nxt   = {ps2d, shreg[7:1]};
               bit_cnt_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  fr_nxt = FR_PARITY;
               end
            end
         end
         FR_PARITY: begin
            if (fall) begin
`ifdef KBD_PARITY_CHECK_EN
               par_ok_nxt = odd_parity_ok(shreg, ps2d);
`endif
               fr_nxt = FR_STOP;
            end
         end
         FR_STOP: begin
            if (fall) begin
               fr_nxt = FR_IDLE;
               if (!ps2d) begin
                  err_nxt = 1'b1;
`ifdef KBD_PARITY_CHECK_EN
               end else if (!par_ok) begin
                  err_nxt = 1'b1;
`endif
               end else begin
                  byte_rdy_nxt = 1'b1;
                  rx_byte_nxt  = shreg;
               end
            end
         end
         default: fr_nxt = FR_IDLE;
      endcase

      if (tmo) begin
         fr_nxt  = FR_IDLE;
         err_nxt = 1'b1;
      end
   end

   assign ext = (dec_state == DEC_E0) || (dec_state == DEC_E0F0);
   assign brk = (dec_state == DEC_F0) || (dec_state == DEC_E0F0);

   ps2_scancode_map u_map_cur (
      .ext   (ext),
      .shift (shift),
      .scan  (rx_byte),
      .code  (code_cur)
   );

   // Unshifted lookup identifies a key independent of shift for break matching.
   ps2_scancode_map u_map_base (
      .ext   (ext),
      .shift (1'b0),
      .scan  (rx_byte),
      .code  (code_base)
   );

   // Decode FSM and keycode registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dec_state   <= DEC_NORM;
         shift       <= 1'b0;
         held_base   <= 16'd0;
         kbd_out     <= 16'd0;
         frame_valid <= 1'b0;
      end else begin
         dec_state   <= dec_nxt;
         shift       <= shift_nxt;
         held_base   <= held_nxt;
         kbd_out     <= kbd_nxt;
         frame_valid <= byte_rdy;
      end
   end

   // Decode next state: prefixes move the FSM, any other byte completes a make or break.
   always_comb begin
      dec_nxt   = dec_state;
      shift_nxt = shift;
      held_nxt  = held_base;
      kbd_nxt   = kbd_out;
      if (byte_rdy) begin
         if (rx_byte == SC_E0) begin
            dec_nxt = DEC_E0;
         end else if (rx_byte == SC_F0) begin
            dec_nxt = (dec_state == DEC_E0) ? DEC_E0F0 : DEC_F0;
         end else begin
            dec_nxt = DEC_NORM;
            if (!ext && (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT)) begin
               shift_nxt = !brk;
            end else if (!brk) begin
               if (code_cur != 16'd0) begin
                  kbd_nxt  = code_cur;
                  held_nxt = code_base;
               end
            end else if (code_base != 16'd0 && code_base == held_base) begin
               kbd_nxt = 16'd0;
            end
         end
      end
   end

endmodule

// File: tb/tb_hack_kbd_writer.sv
// Bench for hack_kbd_writer: directed scenarios then random key events
// against a key-event level reference model.
module tb_hack_kbd_writer;

   localparam int TMO  = 300;
   localparam int HALF = 8;
   localparam int NK   = 17;

   typedef struct {
      logic       ext;
      logic [7:0] sc;
      int         lo;
      int         hi;
      logic       is_shift;
   } key_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] kbd_out;
   logic        frame_valid;
   logic        frame_err;

   int n_checks = 0;
   int n_errors = 0;
   int n_valid  = 0;
   int n_err    = 0;

   key_t keys [NK];
   logic m_shift;
   int   m_kbd;
   int   m_held;

   always #5 clk = ~clk;

   hack_kbd_writer #(
      .TIMEOUT_CYCLES (TMO),
      .SYNC_STAGES    (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .kbd_out     (kbd_out),
      .frame_valid (frame_valid),
      .frame_err   (frame_err)
   );

   always @(negedge clk) begin
      if (frame_valid === 1'b1) n_valid++;
      if (frame_err === 1'b1) n_err++;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
      logic [10:0] f;
      f = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < 11; i++) drive_bit(f[i]);
      ps2_data = 1'b1;
      repeat (3 * HALF) @(negedge clk);
   endtask

   task automatic send_byte_chk(input logic [7:0] b);
      int v0, e0;
      v0 = n_valid;
      e0 = n_err;
      send_frame(b, 1'b1, 1'b0);
      check_val("valid_cnt", n_valid - v0, 1);
      check_val("err_cnt", n_err - e0, 0);
   endtask

   task automatic key_event(input int idx, input logic brk, input string tag);
      key_t k;
      int   code;
      k = keys[idx];
      if (k.ext) send_byte_chk(8'hE0);
      if (brk) send_byte_chk(8'hF0);
      send_byte_chk(k.sc);
      if (k.is_shift) begin
         m_shift = !brk;
      end else if (!brk) begin
         code = m_shift ? k.hi : k.lo;
         if (code != 0) begin
            m_kbd  = code;
            m_held = k.lo;
         end
      end else if (k.lo != 0 && k.lo == m_held) begin
         m_kbd = 0;
      end
      check_val(tag, kbd_out, m_kbd);
   endtask

   task automatic model_reset();
      m_shift = 1'b0;
      m_kbd   = 0;
      m_held  = 0;
   endtask

   initial begin
      int v0, e0;
      keys[0]  = '{1'b0, 8'h1C, 97, 65, 1'b0};
      keys[1]  = '{1'b0, 8'h32, 98, 66, 1'b0};
      keys[2]  = '{1'b0, 8'h21, 99, 67, 1'b0};
      keys[3]  = '{1'b0, 8'h16, 49, 33, 1'b0};
      keys[4]  = '{1'b0, 8'h45, 48, 41, 1'b0};
      keys[5]  = '{1'b0, 8'h29, 32, 32, 1'b0};
      keys[6]  = '{1'b0, 8'h4E, 45, 95, 1'b0};
      keys[7]  = '{1'b0, 8'h5A, 128, 128, 1'b0};
      keys[8]  = '{1'b0, 8'h66, 129, 129, 1'b0};
      keys[9]  = '{1'b0, 8'h05, 141, 141, 1'b0};
      keys[10] = '{1'b0, 8'h07, 152, 152, 1'b0};
      keys[11] = '{1'b1, 8'h75, 131, 131, 1'b0};
      keys[12] = '{1'b1, 8'h71, 139, 139, 1'b0};
      keys[13] = '{1'b1, 8'h6B, 130, 130, 1'b0};
      keys[14] = '{1'b0, 8'h0D, 0, 0, 1'b0};
      keys[15] = '{1'b0, 8'h12, 0, 0, 1'b1};
      keys[16] = '{1'b0, 8'h59, 0, 0, 1'b1};
      model_reset();

      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      check_val("rst_kbd", kbd_out, 0);
      check_val("rst_valid", frame_valid, 0);
      check_val("rst_err", frame_err, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      key_event(0, 1'b0, "make_a");
      key_event(0, 1'b0, "repeat_a");
      key_event(0, 1'b1, "break_a");

      key_event(15, 1'b0, "lshift_make");
      key_event(0, 1'b0, "make_A");
      key_event(15, 1'b1, "lshift_break");
      key_event(0, 1'b1, "break_A");

      key_event(11, 1'b0, "make_up");
      key_event(11, 1'b1, "break_up");
      key_event(12, 1'b0, "make_del");
      key_event(0, 1'b1, "break_other");
      key_event(12, 1'b1, "break_del");

      v0 = n_valid;
      e0 = n_err;
      send_frame(8'h1C, 1'b0, 1'b0);
      check_val("stop0_err", n_err - e0, 1);
      check_val("stop0_valid", n_valid - v0, 0);
      check_val("stop0_kbd", kbd_out, 0);

      v0 = n_valid;
      e0 = n_err;
      send_frame(8'h1C, 1'b1, 1'b1);
`ifdef KBD_PARITY_CHECK_EN
      check_val("par_err", n_err - e0, 1);
      check_val("par_valid", n_valid - v0, 0);
`else
      check_val("par_err", n_err - e0, 0);
      check_val("par_valid", n_valid - v0, 1);
      m_kbd  = 97;
      m_held = 97;
`endif
      check_val("par_kbd", kbd_out, m_kbd);
      key_event(0, 1'b1, "par_release");

      v0 = n_valid;
      e0 = n_err;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(i[0]);
      ps2_data = 1'b1;
      repeat (TMO + 100) @(negedge clk);
      check_val("tmo_err", n_err - e0, 1);
      check_val("tmo_valid", n_valid - v0, 0);
      key_event(0, 1'b0, "tmo_recover");

      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("midrst_kbd", kbd_out, 0);
      check_val("midrst_valid", frame_valid, 0);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      key_event(0, 1'b0, "midrst_recover");
      key_event(0, 1'b1, "midrst_release");

      for (int n = 0; n < 50; n++) begin
         key_event(int'($urandom_range(0, NK - 1)), 1'($urandom_range(0, 1)), "rand_kbd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
